// File: rtl/lcd_hex_display.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_hex_display
//  Purpose  : Drives an HD44780-compatible 16x2 character LCD (write only).
//             It runs the power-up wait and the init commands, then
//             refreshes forever: line 1 shows value[63:32] and line 2 shows
//             value[31:0], each as 8 upper-case hex characters.
//  Ports    : clock       - system clock (50 MHz board clock)
//             reset_n     - asynchronous, active-low reset
//             value       - 64-bit word to display
//             lcd_data    - LCD data bus
//             lcd_rs      - 0 = command, 1 = character data
//             lcd_rw      - tied 0 (write only)
//             lcd_en      - LCD enable strobe
//             init_done   - high once the init sequence has completed
//             frame_done  - one-cycle pulse at the start of every frame
//                           that follows a completed frame
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_hex_display #(
  parameter int POWERUP_CYCLES    = 750000,
  parameter int SETUP_CYCLES      = 4,
  parameter int EN_HIGH_CYCLES    = 16,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 82000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [63:0] value,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        init_done,
  output logic        frame_done
);

  // One counter serves every timed interval, so it is sized for the longest.
  localparam int C_MAX_A = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int C_MAX_B = (CMD_WAIT_CYCLES > EN_HIGH_CYCLES) ? CMD_WAIT_CYCLES : EN_HIGH_CYCLES;
  localparam int C_MAX_C = (C_MAX_B > SETUP_CYCLES) ? C_MAX_B : SETUP_CYCLES;
  localparam int C_MAX   = (C_MAX_A > C_MAX_C) ? C_MAX_A : C_MAX_C;
  localparam int CNT_W   = $clog2(C_MAX + 1);

  localparam logic [CNT_W-1:0] C_PWR_LAST   = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_EN_LAST    = CNT_W'(EN_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CMD_LAST   = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CLR_LAST   = CNT_W'(CLEAR_WAIT_CYCLES - 1);

  typedef enum logic [1:0] {MODE_POWERUP, MODE_INIT, MODE_FRAME} mode_e;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_e;

  mode_e            mode_q, mode_d;
  phase_e           phase_q, phase_d;
  logic [4:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             init_done_q, init_done_d;
  logic             frame_done_q, frame_done_d;
  logic [63:0]      snap_q, snap_d;

  logic             w_start;
  mode_e            w_start_mode;
  logic [4:0]       w_start_idx;
  logic [CNT_W-1:0] w_wait_last;

  // {rs, byte} for write i of the given mode. Frame writes 1-8 and 10-17
  // map onto snapshot nibbles 0-15, most significant nibble first.
  function automatic logic [8:0] write_byte(input mode_e m, input logic [4:0] i,
                                            input logic [63:0] s);
    logic [3:0] k;
    logic [5:0] base;
    logic [3:0] nib;
    logic [8:0] r;
    r = 9'h000;
    if (m == MODE_INIT) begin
      case (i)
        5'd0:    r = {1'b0, 8'h38};
        5'd1:    r = {1'b0, 8'h0C};
        5'd2:    r = {1'b0, 8'h01};
        default: r = {1'b0, 8'h06};
      endcase
    end else if (i == 5'd0) begin
      r = {1'b0, 8'h80};
    end else if (i == 5'd9) begin
      r = {1'b0, 8'hC0};
    end else begin
      k    = (i < 5'd9) ? 4'(i - 5'd1) : 4'(i - 5'd2);
      base = 6'd63 - {k, 2'b00};
      nib  = s[base -: 4];
      r    = {1'b1, (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib})};
    end
    return r;
  endfunction

  // Only the clear command needs the long settle time.
  assign w_wait_last = (!rs_q && data_q == 8'h01) ? C_CLR_LAST : C_CMD_LAST;

  always_comb begin
    mode_d       = mode_q;
    phase_d      = phase_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + 1'b1;
    data_d       = data_q;
    rs_d         = rs_q;
    en_d         = en_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    snap_d       = snap_q;
    w_start      = 1'b0;
    w_start_mode = mode_q;
    w_start_idx  = idx_q;

    case (mode_q)
      MODE_POWERUP: begin
        if (cnt_q == C_PWR_LAST) begin
          w_start      = 1'b1;
          w_start_mode = MODE_INIT;
          w_start_idx  = 5'd0;
        end
      end
      default: begin
        case (phase_q)
          PH_SETUP: begin
            if (cnt_q == C_SETUP_LAST) begin
              phase_d = PH_PULSE;
              cnt_d   = '0;
              en_d    = 1'b1;
            end
          end
          PH_PULSE: begin
            if (cnt_q == C_EN_LAST) begin
              phase_d = PH_WAIT;
              cnt_d   = '0;
              en_d    = 1'b0;
            end
          end
          default: begin
            if (cnt_q == w_wait_last) begin
              w_start = 1'b1;
              if (mode_q == MODE_INIT) begin
                if (idx_q == 5'd3) begin
                  w_start_mode = MODE_FRAME;
                  w_start_idx  = 5'd0;
                  init_done_d  = 1'b1;
                end else begin
                  w_start_idx = idx_q + 5'd1;
                end
              end else if (idx_q == 5'd17) begin
                w_start_idx  = 5'd0;
                frame_done_d = 1'b1;
              end else begin
                w_start_idx = idx_q + 5'd1;
              end
            end
          end
        endcase
      end
    endcase

    // Entering SETUP of the next write: present rs/data immediately.
    if (w_start) begin
      mode_d          = w_start_mode;
      idx_d           = w_start_idx;
      phase_d         = PH_SETUP;
      cnt_d           = '0;
      en_d            = 1'b0;
      {rs_d, data_d}  = write_byte(w_start_mode, w_start_idx, snap_q);
      // The frame is latched as a whole so a mid-frame change cannot tear it.
      if (w_start_mode == MODE_FRAME && w_start_idx == 5'd0) begin
        snap_d = value;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q       <= MODE_POWERUP;
      phase_q      <= PH_SETUP;
      idx_q        <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      snap_q       <= '0;
    end else begin
      mode_q       <= mode_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      rs_q         <= rs_d;
      en_q         <= en_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      snap_q       <= snap_d;
    end
  end

  assign lcd_data   = data_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = en_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hex_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_hex_display
//  Purpose  : Self-checking bench for lcd_hex_display with short timing
//             parameters. EN rising edges are logged with their cycle number
//             (rising edges since reset release) and checked against
//             spec-derived timing and content.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_hex_display;

  localparam int P_PWR = 10, P_SET = 2, P_EN = 3, P_CMD = 5, P_CLR = 20;
  localparam int WP        = P_SET + P_EN + P_CMD;          // 10
  localparam int WP_CLR    = P_SET + P_EN + P_CLR;          // 25
  localparam int FIRST_SET = P_PWR;                         // 10
  localparam int INIT_RISE = FIRST_SET + 3 * WP + WP_CLR;   // 65

  logic        clock = 1'b0;
  logic        reset_n;
  logic [63:0] value;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, init_done, frame_done;

  lcd_hex_display #(
    .POWERUP_CYCLES(P_PWR), .SETUP_CYCLES(P_SET), .EN_HIGH_CYCLES(P_EN),
    .CMD_WAIT_CYCLES(P_CMD), .CLEAR_WAIT_CYCLES(P_CLR)
  ) dut (
    .clock(clock), .reset_n(reset_n), .value(value),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct { int cyc; logic rs; logic [7:0] d; } ev_t;
  typedef struct { logic rs; logic [7:0] d; int rise; } iv_t;
  typedef struct { logic [63:0] val; logic [127:0] chars; } vec_t;

  ev_t evq[$];
  int  n_checks = 0, n_pass = 0;
  int  cyc = 0, rise_cyc = 0, first_width = -1, en_width_bad = 0;
  int  init_rise_cyc = -1, last_fd_cyc = -1, n_fd = 0, fd_bad = 0, rw_bad = 0;
  logic en_prev = 1'b0, fd_prev = 1'b0, id_prev = 1'b0;
  int  last_ev_cyc = 0, prev_fd = -1;
  bit  first_frame = 1'b1;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (lcd_rw !== 1'b0) rw_bad++;
    if (!reset_n) begin
      cyc = 0; en_prev = 1'b0; fd_prev = 1'b0; id_prev = 1'b0;
    end else begin
      cyc++;
      if (lcd_en && !en_prev) begin
        evq.push_back('{cyc, lcd_rs, lcd_data});
        rise_cyc = cyc;
      end
      if (!lcd_en && en_prev) begin
        if (first_width < 0) first_width = cyc - rise_cyc;
        if (cyc - rise_cyc != P_EN) en_width_bad++;
      end
      if (frame_done) begin
        if (fd_prev) fd_bad++;
        last_fd_cyc = cyc;
        n_fd++;
      end
      if (init_done && !id_prev) init_rise_cyc = cyc;
      en_prev = lcd_en; fd_prev = frame_done; id_prev = init_done;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic get_ev(output ev_t e);
    int t = 0;
    while (evq.size() == 0 && t < 60) begin
      @(negedge clock);
      t++;
    end
    if (evq.size() == 0) begin
      check("timeout waiting for EN strobe", 0, 1);
      e = '{-1, 1'bx, 8'hxx};
    end else begin
      e = evq.pop_front();
    end
  endtask

  // Reference: hex characters of a value, computed arithmetically.
  function automatic logic [127:0] model_chars(input logic [63:0] v);
    logic [127:0] r;
    int n;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      n = int'((v >> (60 - 4 * j)) & 64'hF);
      r[127 - 8 * j -: 8] = (n < 10) ? 8'(48 + n) : 8'(55 + n);
    end
    return r;
  endfunction

  task automatic do_init();
    iv_t itbl[4];
    ev_t e;
    itbl[0] = '{1'b0, 8'h38, FIRST_SET + P_SET};
    itbl[1] = '{1'b0, 8'h0C, FIRST_SET + WP + P_SET};
    itbl[2] = '{1'b0, 8'h01, FIRST_SET + 2 * WP + P_SET};
    itbl[3] = '{1'b0, 8'h06, FIRST_SET + 2 * WP + WP_CLR + P_SET};
    for (int k = 0; k < 4; k++) begin
      get_ev(e);
      check($sformatf("init%0d rs", k), e.rs, itbl[k].rs);
      check($sformatf("init%0d data", k), e.d, itbl[k].d);
      check($sformatf("init%0d EN rise cycle", k), e.cyc, itbl[k].rise);
      last_ev_cyc = e.cyc;
    end
    check("first EN high width", first_width, P_EN);
  endtask

  task automatic run_frame(input logic [127:0] exp, input int change_at,
                           input logic [63:0] nv, input string tag);
    ev_t e;
    int  j;
    for (int k = 0; k < 18; k++) begin
      get_ev(e);
      check({tag, " write spacing"}, e.cyc - last_ev_cyc, WP);
      last_ev_cyc = e.cyc;
      if (k == 0) begin
        check({tag, " 0x80"}, {e.rs, e.d}, {1'b0, 8'h80});
        if (first_frame) begin
          check("init_done rise cycle", init_rise_cyc, INIT_RISE);
          check("init_done with first 0x80 setup", init_rise_cyc, e.cyc - P_SET);
          check("no frame_done before first frame", n_fd, 0);
          first_frame = 1'b0;
        end else begin
          check({tag, " frame_done at 0x80 setup"}, last_fd_cyc, e.cyc - P_SET);
          if (prev_fd >= 0) check({tag, " frame_done period"}, last_fd_cyc - prev_fd, 18 * WP);
          prev_fd = last_fd_cyc;
        end
      end else if (k == 9) begin
        check({tag, " 0xC0"}, {e.rs, e.d}, {1'b0, 8'hC0});
      end else begin
        j = (k < 9) ? k - 1 : k - 2;
        check($sformatf("%s char%0d", tag, j), {e.rs, e.d}, {1'b1, exp[127 - 8 * j -: 8]});
      end
      if (k == change_at) value = nv;
    end
  endtask

  initial begin
    vec_t tbl[3];
    ev_t e;
    logic [63:0] rv, nv;
    int t;
    tbl[0] = '{64'h0123_4567_89AB_CDEF, "0123456789ABCDEF"};
    tbl[1] = '{64'h0, {16{8'h30}}};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, {16{8'h46}}};

    reset_n = 1'b0;
    value   = tbl[0].val;
    repeat (3) @(negedge clock);
    check("reset lcd_en", lcd_en, 0);
    check("reset lcd_rs/data", {lcd_rs, lcd_data}, 0);
    check("reset init_done/frame_done", {init_done, frame_done}, 0);
    #2 reset_n = 1'b1;

    do_init();

    // Table: each frame shows the entry's value; the next entry's value is
    // applied just after the 0x80 snapshot of the current frame.
    for (int i = 0; i < 3; i++) begin
      run_frame(tbl[i].chars, 0, tbl[(i + 1) % 3].val, $sformatf("tbl%0d", i));
    end

    // Change mid-line-1: the current frame keeps the old snapshot.
    run_frame(tbl[0].chars, 3, tbl[2].val, "midframe");
    rv = {$urandom, $urandom};
    run_frame(tbl[2].chars, 0, rv, "after change");

    for (int r = 0; r < 5; r++) begin
      nv = {$urandom, $urandom};
      run_frame(model_chars(rv), 0, nv, $sformatf("rand%0d", r));
      rv = nv;
    end

    // Asynchronous reset while EN is high on a character write.
    get_ev(e);
    get_ev(e);
    t = 0;
    while (!(lcd_en === 1'b1 && lcd_rs === 1'b1) && t < 50) begin
      @(negedge clock);
      t++;
    end
    check("EN high before async reset", {lcd_en, lcd_rs}, 2'b11);
    check("init_done before async reset", init_done, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset lcd_en", lcd_en, 0);
    check("async reset rs/data", {lcd_rs, lcd_data}, 0);
    check("async reset init_done", init_done, 0);
    repeat (3) @(negedge clock);
    evq.delete();
    first_width = -1; init_rise_cyc = -1; n_fd = 0; last_fd_cyc = -1; prev_fd = -1;
    first_frame = 1'b1;
    #2 reset_n = 1'b1;
    do_init();
    run_frame(model_chars(rv), -1, 64'h0, "post reset");

    check("lcd_rw never high", rw_bad, 0);
    check("all EN widths", en_width_bad, 0);
    check("frame_done single-cycle", fd_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
